instr_loader: RTL and testbench
===============================

INSTR_LOADER -- requirements
Module: instr_loader

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 80000000, clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, serial bit rate.
REQ-003 SHALL have parameter DEPTH, default 256, instruction memory depth in 32-bit words.
REQ-004 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port arstn  input  1  asynchronous active-low reset.
REQ-006 SHALL have port rx  input  1  UART serial in, idle high, 8N1, LSB first.
REQ-007 SHALL have port mem_we  output  1  instruction memory write strobe, one cycle per word.
REQ-008 SHALL have port mem_addr  output  32  byte address of the written word (multiple of 4).
REQ-009 SHALL have port mem_wdata  output  32  instruction word to write.
REQ-010 SHALL have port core_rstn  output  1  active-low reset to the processor core; low while loading.
REQ-011 SHALL have port busy  output  1  high from the first accepted start bit until done or err.
REQ-012 SHALL have port done  output  1  sticky; image fully written.
REQ-013 SHALL have port err  output  1  sticky; framing or length error.

Function
REQ-014 SHALL pass rx through a 2-flop synchronizer before any use; idle value of the synchronizer is 1.
REQ-015 SHALL use CLKS_PER_BIT = CLK_FREQ/BAUD, truncated (694 at defaults).
REQ-016 SHALL enter RX_START on a synchronized 1->0 transition while RX_IDLE, and re-sample at CLKS_PER_BIT/2; rx=1 there -> glitch, back to RX_IDLE, no byte.
REQ-017 SHALL sample 8 data bits at CLKS_PER_BIT intervals from mid-start, LSB first, then the stop bit one interval later.
REQ-018 SHALL, on stop bit = 1, pulse an internal byte_valid for one cycle; stop bit = 0 -> framing error.
REQ-019 SHALL run the loader FSM: LEN0 -> LEN1 -> DATA -> DONE, plus ERR; reset state LEN0.
REQ-020 SHALL take byte 1 as count[7:0] (LEN0) and byte 2 as count[15:8] (LEN1): word count N, little-endian.
REQ-021 SHALL, in LEN1: N = 0 -> DONE; N > DEPTH -> ERR; otherwise -> DATA with word_idx = 0, byte_idx = 0.
REQ-022 SHALL assemble 4 data bytes little-endian (first byte -> bits 7:0, fourth -> bits 31:24).
REQ-023 SHALL, in the cycle after the fourth byte_valid, drive mem_we = 1 for exactly one cycle with mem_addr = word_idx*4 and mem_wdata = assembled word; mem_addr/mem_wdata hold until the next write.
REQ-024 SHALL increment word_idx after each write; the write with word_idx = N-1 moves the FSM to DONE in the same cycle as that mem_we.
REQ-025 SHALL assert done and core_rstn = 1 starting the cycle after entering DONE; both stay until arstn.
REQ-026 SHALL enter ERR on any framing error in LEN0/LEN1/DATA; in ERR: err = 1, core_rstn = 0, mem_we = 0, busy = 0, until arstn.
REQ-027 SHALL ignore all rx bytes in DONE and ERR (receiver may run; no writes, no state change).
REQ-028 SHALL keep core_rstn = 0 in every state except DONE.
REQ-029 SHALL tolerate back-to-back frames (next start bit directly after stop bit) without byte loss.
REQ-030 SHALL write at most one word per 4 bytes; mem_we never asserted two consecutive cycles.

Reset
REQ-031 SHALL, while arstn = 0, force: mem_we 0, mem_addr 0, mem_wdata 0, core_rstn 0, busy 0, done 0, err 0, FSM LEN0, receiver RX_IDLE, synchronizer 1.
REQ-032 SHALL, on arstn asserted mid-frame or mid-word, discard partial byte and partial word; after release the next start bit is treated as LEN0.
REQ-033 SHALL resume operation on the first clk edge after arstn deasserts; no words written before reset are re-written.

Verification
REQ-034 SHALL cover: bytes 02 00 13 05 A0 00 93 05 10 00 -> mem_we at addr 0x0 wdata 0x00A00513, at addr 0x4 wdata 0x00100593, then done = 1, core_rstn = 1.
REQ-035 SHALL cover: bytes 00 00 -> no mem_we, done = 1, core_rstn = 1 one cycle after second stop bit sample.
REQ-036 SHALL cover: bytes 01 01 (N = 257 > 256) -> err = 1, core_rstn stays 0, no mem_we; later bytes ignored.
REQ-037 SHALL cover: stop bit driven 0 on third data byte -> err = 1, no mem_we for that word, core_rstn 0.
REQ-038 SHALL cover: rx low pulse of 100 cycles while idle -> no byte, FSM stays LEN0, busy stays 0.
REQ-039 SHALL cover: arstn pulsed low after 2 of 4 data bytes, then full 01 00 78 56 34 12 -> single mem_we addr 0x0 wdata 0x12345678, done = 1.

Source files
------------

// File: rtl/instr_loader.sv
// instr_loader
// Receives a program image over a UART line and writes it into instruction
// memory, holding the processor core in reset until the image is complete.
// Image format: 16-bit little-endian word count N, then N 32-bit words, each
// sent as 4 bytes in little-endian order.
//
// Ports
//   clk        in   rising-edge clock for all logic
//   arstn      in   asynchronous active-low reset
//   rx         in   UART serial input (idle high, 8N1, LSB first)
//   mem_we     out  one-cycle write strobe per assembled word
//   mem_addr   out  byte address of the written word (word_idx*4), held
//   mem_wdata  out  assembled instruction word, held
//   core_rstn  out  core reset, released only once the image is complete
//   busy       out  high from the first accepted start bit until done/err
//   done       out  sticky, image fully written
//   err        out  sticky, framing or length error
module instr_loader #(
  parameter int CLK_FREQ = 80000000,
  parameter int BAUD     = 115200,
  parameter int DEPTH    = 256
) (
  input  logic        clk,
  input  logic        arstn,
  input  logic        rx,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        core_rstn,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int CPB  = CLK_FREQ / BAUD;
  localparam int HALF = CPB / 2;
  localparam int CW   = $clog2(CPB + 1);
  localparam logic [CW-1:0] CPB_M1  = CW'(CPB - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
  localparam logic [31:0]   DEPTH_U = 32'(DEPTH);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {LEN0, LEN1, DATA, DONE, ERR} ld_state_t;

  // ---------------- receiver ----------------
  logic            sync1_q, sync2_q, prev_q;
  rx_state_t       rx_state_q, rx_state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            byte_valid_q, byte_valid_d;
  logic            frame_err_q, frame_err_d;
  logic            start_ok;

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      prev_q       <= 1'b1;
      rx_state_q   <= RX_IDLE;
      cnt_q        <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      sync1_q      <= rx;
      sync2_q      <= sync1_q;
      prev_q       <= sync2_q;
      rx_state_q   <= rx_state_d;
      cnt_q        <= cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  always_comb begin
    rx_state_d   = rx_state_q;
    cnt_d        = cnt_q;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    start_ok     = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (prev_q && !sync2_q) rx_state_d = RX_START;
      end
      RX_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d = '0;
          // Line back high at mid-start: treat as a glitch.
          if (sync2_q) begin
            rx_state_d = RX_IDLE;
          end else begin
            rx_state_d = RX_DATA;
            bit_idx_d  = '0;
            start_ok   = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RX_DATA: begin
        if (cnt_q == CPB_M1) begin
          cnt_d     = '0;
          shift_d   = {sync2_q, shift_q[7:1]};  // LSB arrives first
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) rx_state_d = RX_STOP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RX_STOP: begin
        if (cnt_q == CPB_M1) begin
          // Back to idle at mid-stop so a directly following start edge is seen.
          cnt_d      = '0;
          rx_state_d = RX_IDLE;
          if (sync2_q) byte_valid_d = 1'b1;
          else         frame_err_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // ---------------- loader ----------------
  ld_state_t    state_q, state_d;
  logic [15:0]  count_q, count_d;
  logic [15:0]  word_idx_q, word_idx_d;
  logic [1:0]   byte_idx_q, byte_idx_d;
  logic [23:0]  word_q, word_d;
  logic         mem_we_q, mem_we_d;
  logic [31:0]  mem_addr_q, mem_addr_d;
  logic [31:0]  mem_wdata_q, mem_wdata_d;
  logic         started_q;
  logic [15:0]  len_n;

  assign len_n = {shift_q, count_q[7:0]};

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state_q     <= LEN0;
      count_q     <= '0;
      word_idx_q  <= '0;
      byte_idx_q  <= '0;
      word_q      <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      started_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      word_idx_q  <= word_idx_d;
      byte_idx_q  <= byte_idx_d;
      word_q      <= word_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if (start_ok) started_q <= 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    word_idx_d  = word_idx_q;
    byte_idx_d  = byte_idx_q;
    word_d      = word_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      LEN0: begin
        if (frame_err_q) begin
          state_d = ERR;
        end else if (byte_valid_q) begin
          count_d[7:0] = shift_q;
          state_d      = LEN1;
        end
      end
      LEN1: begin
        if (frame_err_q) begin
          state_d = ERR;
        end else if (byte_valid_q) begin
          count_d = len_n;
          if (len_n == 16'd0)                 state_d = DONE;
          else if ({16'd0, len_n} > DEPTH_U)  state_d = ERR;
          else begin
            state_d    = DATA;
            word_idx_d = '0;
            byte_idx_d = '0;
          end
        end
      end
      DATA: begin
        if (frame_err_q) begin
          state_d = ERR;
        end else if (byte_valid_q) begin
          case (byte_idx_q)
            2'd0: word_d[7:0]   = shift_q;
            2'd1: word_d[15:8]  = shift_q;
            2'd2: word_d[23:16] = shift_q;
            default: begin
              mem_we_d    = 1'b1;
              mem_addr_d  = {14'd0, word_idx_q, 2'b00};
              mem_wdata_d = {shift_q, word_q};
              word_idx_d  = word_idx_q + 16'd1;
              if (word_idx_q == count_q - 16'd1) state_d = DONE;
            end
          endcase
          byte_idx_d = byte_idx_q + 2'd1;
        end
      end
      DONE:    state_d = DONE;
      ERR:     state_d = ERR;
      default: state_d = ERR;
    endcase
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign done      = (state_q == DONE);
  assign err       = (state_q == ERR);
  assign core_rstn = (state_q == DONE);
  assign busy      = started_q &&
                     (state_q == LEN0 || state_q == LEN1 || state_q == DATA);

endmodule

// File: tb/tb_instr_loader.sv
module tb_instr_loader;

  // 208 clocks per bit: half a bit (104) is longer than the 100-cycle glitch.
  localparam int CLK_FREQ = 20800000;
  localparam int BAUD     = 100000;
  localparam int CPB      = 208;

  logic        clk = 1'b0;
  logic        arstn;
  logic        rx;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        core_rstn;
  logic        busy;
  logic        done;
  logic        err;

  int n_cmp = 0;
  int n_err = 0;

  instr_loader #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DEPTH(256)) dut (
    .clk(clk), .arstn(arstn), .rx(rx),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .core_rstn(core_rstn), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Write monitor: logs every strobe and counts back-to-back strobes.
  logic [31:0] log_addr[$];
  logic [31:0] log_data[$];
  int   consec  = 0;
  logic prev_we = 1'b0;

  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      log_addr.push_back(mem_addr);
      log_data.push_back(mem_wdata);
      $display("write addr=%h data=%h", mem_addr, mem_wdata);
      if (prev_we) consec++;
    end
    prev_we = (mem_we === 1'b1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] get_addr(input int i);
    if (i < log_addr.size()) return log_addr[i];
    return 32'hxxxxxxxx;
  endfunction

  function automatic logic [31:0] get_data(input int i);
    if (i < log_data.size()) return log_data[i];
    return 32'hxxxxxxxx;
  endfunction

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_v, input int stop_len);
    rx = 1'b0;
    wait_cycles(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_cycles(CPB);
    end
    rx = stop_v;
    wait_cycles(stop_len);
    $display("byte %h sent stop=%0b", b, stop_v);
  endtask

  task automatic send(input logic [7:0] b);
    send_byte(b, 1'b1, CPB);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_we"},    {31'd0, mem_we},    32'd0);
    chk({tag, "_addr"},  mem_addr,           32'd0);
    chk({tag, "_wdata"}, mem_wdata,          32'd0);
    chk({tag, "_crst"},  {31'd0, core_rstn}, 32'd0);
    chk({tag, "_busy"},  {31'd0, busy},      32'd0);
    chk({tag, "_done"},  {31'd0, done},      32'd0);
    chk({tag, "_err"},   {31'd0, err},       32'd0);
  endtask

  task automatic do_reset();
    rx    = 1'b1;
    arstn = 1'b0;
    wait_cycles(3);
    arstn = 1'b1;
    wait_cycles(4);
  endtask

  initial begin
    int base;
    rx    = 1'b1;
    arstn = 1'b0;
    wait_cycles(3);
    chk_reset_outputs("rst");
    arstn = 1'b1;
    wait_cycles(4);
    chk_reset_outputs("idle");

    // Two-word image.
    base = log_addr.size();
    send(8'h02);
    chk("t1_busy_after_len0", {31'd0, busy},      32'd1);
    chk("t1_crst_loading",    {31'd0, core_rstn}, 32'd0);
    send(8'h00);
    send(8'h13); send(8'h05); send(8'hA0); send(8'h00);
    send(8'h93); send(8'h05); send(8'h10); send(8'h00);
    chk("t1_we_count", 32'(log_addr.size() - base), 32'd2);
    chk("t1_addr0",  get_addr(base),     32'h0);
    chk("t1_data0",  get_data(base),     32'h00A00513);
    chk("t1_addr1",  get_addr(base + 1), 32'h4);
    chk("t1_data1",  get_data(base + 1), 32'h00100593);
    chk("t1_hold_addr",  mem_addr,  32'h4);
    chk("t1_hold_wdata", mem_wdata, 32'h00100593);
    chk("t1_done", {31'd0, done},      32'd1);
    chk("t1_crst", {31'd0, core_rstn}, 32'd1);
    chk("t1_busy", {31'd0, busy},      32'd0);
    chk("t1_err",  {31'd0, err},       32'd0);
    chk("t1_consec", 32'(consec), 32'd0);
    // Bytes after completion are ignored.
    send(8'h55);
    chk("t1_ignored_we", 32'(log_addr.size() - base), 32'd2);
    chk("t1_still_done", {31'd0, done}, 32'd1);

    // Empty image: done one cycle after the second stop-bit sample.
    // Relative to the start edge P0 the stop sample lands on P1979
    // (2 sync + 1 edge + 104 half bit + 9*208), so done rises at P1980.
    do_reset();
    base = log_addr.size();
    send(8'h00);
    send_byte(8'h00, 1'b1, 107);
    chk("t2_done_early", {31'd0, done}, 32'd0);
    wait_cycles(1);
    chk("t2_done",  {31'd0, done},      32'd1);
    chk("t2_crst",  {31'd0, core_rstn}, 32'd1);
    wait_cycles(CPB - 108);
    chk("t2_no_we", 32'(log_addr.size() - base), 32'd0);

    // Length 257 exceeds the memory.
    do_reset();
    base = log_addr.size();
    send(8'h01); send(8'h01);
    chk("t3_err",  {31'd0, err},       32'd1);
    chk("t3_crst", {31'd0, core_rstn}, 32'd0);
    chk("t3_busy", {31'd0, busy},      32'd0);
    send(8'h00);
    chk("t3_err_sticky", {31'd0, err},  32'd1);
    chk("t3_done",       {31'd0, done}, 32'd0);
    chk("t3_no_we", 32'(log_addr.size() - base), 32'd0);

    // Framing error on the third data byte.
    do_reset();
    base = log_addr.size();
    send(8'h01); send(8'h00); send(8'h11); send(8'h22);
    chk("t4_err_before", {31'd0, err}, 32'd0);
    send_byte(8'h33, 1'b0, CPB);
    rx = 1'b1;
    wait_cycles(50);
    chk("t4_err",  {31'd0, err},       32'd1);
    chk("t4_crst", {31'd0, core_rstn}, 32'd0);
    chk("t4_busy", {31'd0, busy},      32'd0);
    send(8'h44);
    chk("t4_no_we", 32'(log_addr.size() - base), 32'd0);

    // 100-cycle low glitch while idle, then an empty image proves LEN0.
    do_reset();
    base = log_addr.size();
    rx = 1'b0;
    wait_cycles(100);
    rx = 1'b1;
    wait_cycles(400);
    chk("t5_busy", {31'd0, busy}, 32'd0);
    chk("t5_err",  {31'd0, err},  32'd0);
    chk("t5_done", {31'd0, done}, 32'd0);
    send(8'h00); send(8'h00);
    chk("t5_done_after", {31'd0, done}, 32'd1);
    chk("t5_no_we", 32'(log_addr.size() - base), 32'd0);

    // Reset mid-word, then a full one-word image.
    do_reset();
    base = log_addr.size();
    send(8'h01); send(8'h00); send(8'hAA); send(8'hBB);
    arstn = 1'b0;
    wait_cycles(2);
    chk_reset_outputs("t6_rst");
    arstn = 1'b1;
    wait_cycles(4);
    send(8'h01); send(8'h00); send(8'h78); send(8'h56); send(8'h34); send(8'h12);
    chk("t6_we_count", 32'(log_addr.size() - base), 32'd1);
    chk("t6_addr", get_addr(base), 32'h0);
    chk("t6_data", get_data(base), 32'h12345678);
    chk("t6_done", {31'd0, done},      32'd1);
    chk("t6_crst", {31'd0, core_rstn}, 32'd1);
    chk("t6_consec", 32'(consec), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
